// File: rtl/hazard_forward_scoreboard_pkg.sv
// Shared constants for the hazard / forwarding unit.
//   FWD_RF       : forward select value meaning "use register file"
//   fwd_stage(k) : forward select value meaning "use result of stage k"
//   X0_ADDR      : hardwired-zero register address
//   DEF_NREG/AW  : default architectural register count and address width
package hazard_forward_scoreboard_pkg;

   localparam int DEF_NREG = 32;
   localparam int DEF_AW   = 5;
   localparam int X0_ADDR  = 0;
   localparam int FWD_RF   = 0;

   // Stage k (0 = EX/MEM, 1 = MEM/WB, ...) is encoded as k+1 so that 0 stays
   // free for the register-file path.
   function automatic int fwd_stage(input int k);
      return k + 1;
   endfunction

endpackage

// File: rtl/hazard_forward_scoreboard_if.sv
// Pipeline-side bundle of the hazard / forwarding unit.
//   master : pipeline side, drives EX/ID/forwarding/writeback information,
//            receives forward selects, stall and scoreboard status.
//   slave  : the hazard unit itself.
// stall_cnt is a debug view of the watchdog counter.
// Handshake: there is no valid/ready pair here; id_valid, ex_valid and
// mc_wb_valid are single-cycle qualifiers sampled on each rising clk edge,
// and stall_id is the only back-pressure (ID holds while it is high).
interface hazard_forward_scoreboard_if #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int NSRC = 2,
   parameter int NFWD = 2,
   parameter int SELW = 2,
   parameter int CNTW = 6
);
   logic [NSRC*AW-1:0]   ex_rs_addr;
   logic [NSRC-1:0]      ex_rs_used;
   logic [NFWD-1:0]      fwd_reg_write;
   logic [NFWD*AW-1:0]   fwd_rd;
   logic [NSRC*SELW-1:0] forward_sel;
   logic                 id_valid;
   logic [NSRC*AW-1:0]   id_rs_addr;
   logic [NSRC-1:0]      id_rs_used;
   logic [AW-1:0]        id_rd;
   logic                 id_reg_write;
   logic                 id_is_mc;
   logic                 ex_valid;
   logic                 ex_is_load;
   logic                 ex_reg_write;
   logic [AW-1:0]        ex_rd;
   logic                 mc_wb_valid;
   logic [AW-1:0]        mc_wb_rd;
   logic                 stall_id;
   logic [NREG-1:0]      pending;
   logic                 mc_busy;
   logic                 sb_err;
   logic                 deadlock;
   logic [CNTW-1:0]      stall_cnt;

   modport master (
      output ex_rs_addr, ex_rs_used, fwd_reg_write, fwd_rd,
      output id_valid, id_rs_addr, id_rs_used, id_rd, id_reg_write, id_is_mc,
      output ex_valid, ex_is_load, ex_reg_write, ex_rd, mc_wb_valid, mc_wb_rd,
      input  forward_sel, stall_id, pending, mc_busy, sb_err, deadlock, stall_cnt
   );

   modport slave (
      input  ex_rs_addr, ex_rs_used, fwd_reg_write, fwd_rd,
      input  id_valid, id_rs_addr, id_rs_used, id_rd, id_reg_write, id_is_mc,
      input  ex_valid, ex_is_load, ex_reg_write, ex_rd, mc_wb_valid, mc_wb_rd,
      output forward_sel, stall_id, pending, mc_busy, sb_err, deadlock, stall_cnt
   );
endinterface

// File: rtl/hazard_forward_scoreboard_fwd_select.sv
// Combinational forwarding priority matcher for one EX source operand.
//   rs_addr_i       : operand address
//   rs_used_i       : operand is actually read
//   fwd_reg_write_i : per-stage write enable (stage 0 nearest)
//   fwd_rd_i        : per-stage destination, stage k at [k*AW +: AW]
//   sel_o           : FWD_RF, or fwd_stage(k) of the nearest matching stage
module hazard_fwd_select
   import hazard_forward_scoreboard_pkg::*;
#(
   parameter int AW   = DEF_AW,
   parameter int NFWD = 2,
   parameter int SELW = 2
) (
   input  logic [AW-1:0]      rs_addr_i,
   input  logic               rs_used_i,
   input  logic [NFWD-1:0]    fwd_reg_write_i,
   input  logic [NFWD*AW-1:0] fwd_rd_i,
   output logic [SELW-1:0]    sel_o
);

   // Walk from the farthest stage to the nearest so the nearest match is the
   // last assignment and therefore wins.
   always_comb begin
      sel_o = SELW'(FWD_RF);
      for (int k = NFWD - 1; k >= 0; k--) begin
         if (rs_used_i && fwd_reg_write_i[k] &&
             (fwd_rd_i[k*AW +: AW] != AW'(X0_ADDR)) &&
             (fwd_rd_i[k*AW +: AW] == rs_addr_i)) begin
            sel_o = SELW'(fwd_stage(k));
         end
      end
   end

endmodule

// File: rtl/hazard_forward_scoreboard.sv
// Hazard unit: EX forwarding selects, ID load-use detection, and a registered
// scoreboard of destinations owned by the long-latency (mul/div) unit.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : slave side of hazard_forward_scoreboard_if (all pipeline
//                inputs, forward_sel, stall_id, pending, mc_busy, sb_err,
//                deadlock, stall_cnt debug view)
module hazard_forward_scoreboard
   import hazard_forward_scoreboard_pkg::*;
#(
   parameter int NREG     = DEF_NREG,
   parameter int AW       = DEF_AW,
   parameter int NSRC     = 2,
   parameter int NFWD     = 2,
   parameter int SELW     = 2,
   parameter int WDOG_MAX = 40
) (
   input logic                      clk,
   input logic                      rst_n,
   hazard_forward_scoreboard_if.slave bus
);

   localparam int CNTW = $clog2(WDOG_MAX + 1);
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(WDOG_MAX);

   logic [NREG-1:0]      pending_q, pending_d;
   logic                 mc_busy_q, mc_busy_d;
   logic                 sb_err_q,  sb_err_d;
   logic                 dead_q,    dead_d;
   logic [CNTW-1:0]      cnt_q,     cnt_d;
   logic [NSRC*SELW-1:0] fwd_sel;
   logic                 load_use;
   logic                 sb_hazard;
   logic                 stall;
   logic                 issue;

   for (genvar g = 0; g < NSRC; g++) begin : g_fwd
      hazard_fwd_select #(.AW(AW), .NFWD(NFWD), .SELW(SELW)) u_sel (
         .rs_addr_i       (bus.ex_rs_addr[g*AW +: AW]),
         .rs_used_i       (bus.ex_rs_used[g]),
         .fwd_reg_write_i (bus.fwd_reg_write),
         .fwd_rd_i        (bus.fwd_rd),
         .sel_o           (fwd_sel[g*SELW +: SELW])
      );
   end

   // Hazard detection looks only at registered scoreboard state, so a
   // writeback in the current cycle does not release a stall until the next.
   always_comb begin
      load_use  = 1'b0;
      sb_hazard = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (bus.id_rs_used[i]) begin
            if (bus.ex_valid && bus.ex_is_load && bus.ex_reg_write &&
                (bus.ex_rd != AW'(X0_ADDR)) &&
                (bus.id_rs_addr[i*AW +: AW] == bus.ex_rd)) begin
               load_use = 1'b1;
            end
            if ((bus.id_rs_addr[i*AW +: AW] != AW'(X0_ADDR)) &&
                pending_q[bus.id_rs_addr[i*AW +: AW]]) begin
               sb_hazard = 1'b1;
            end
         end
      end
      if (bus.id_reg_write && (bus.id_rd != AW'(X0_ADDR)) && pending_q[bus.id_rd]) begin
         sb_hazard = 1'b1;
      end
      if (bus.id_is_mc && mc_busy_q) begin
         sb_hazard = 1'b1;
      end
      stall = bus.id_valid && (load_use || sb_hazard);
      issue = bus.id_valid && !stall && bus.id_is_mc;
   end

   // Writeback clear is applied before the issue set so a same-rd set wins.
   always_comb begin
      pending_d = pending_q;
      mc_busy_d = mc_busy_q;
      sb_err_d  = sb_err_q;
      if (bus.mc_wb_valid) begin
         mc_busy_d = 1'b0;
         if (bus.mc_wb_rd != AW'(X0_ADDR)) begin
            if (pending_q[bus.mc_wb_rd]) begin
               pending_d[bus.mc_wb_rd] = 1'b0;
            end else begin
               sb_err_d = 1'b1;
            end
         end
      end
      if (issue) begin
         mc_busy_d = 1'b1;
         if (bus.id_reg_write && (bus.id_rd != AW'(X0_ADDR))) begin
            pending_d[bus.id_rd] = 1'b1;
         end
      end
   end

   // Watchdog: counts consecutive stall cycles, saturating at WDOG_MAX.
   always_comb begin
      cnt_d  = '0;
      dead_d = dead_q;
      if (stall) begin
         cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      end
      if (cnt_d == CNT_MAX) begin
         dead_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         mc_busy_q <= 1'b0;
         sb_err_q  <= 1'b0;
         dead_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         pending_q <= pending_d;
         mc_busy_q <= mc_busy_d;
         sb_err_q  <= sb_err_d;
         dead_q    <= dead_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.forward_sel = fwd_sel;
   assign bus.stall_id    = stall;
   assign bus.pending     = pending_q;
   assign bus.mc_busy     = mc_busy_q;
   assign bus.sb_err      = sb_err_q;
   assign bus.deadlock    = dead_q;
   assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
module tb_hazard_forward_scoreboard;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int NSRC = 2;
   localparam int NFWD = 2;
   localparam int SELW = 2;
   localparam int WDOG = 40;
   localparam int CNTW = 6;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   hazard_forward_scoreboard_if #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .NFWD(NFWD),
                                  .SELW(SELW), .CNTW(CNTW)) bus ();

   hazard_forward_scoreboard #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .NFWD(NFWD),
                               .SELW(SELW), .WDOG_MAX(WDOG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   // Scoreboard as a set of owned registers, watchdog as a plain integer.
   bit [NREG-1:0] m_pending;
   bit            m_busy, m_err, m_dead;
   int            m_cnt;

   function automatic int ex_rs(int i);
      return int'(bus.ex_rs_addr[i*AW +: AW]);
   endfunction
   function automatic int id_rs(int i);
      return int'(bus.id_rs_addr[i*AW +: AW]);
   endfunction

   // Nearest writing stage whose destination equals the operand wins.
   function automatic int exp_fwd(int i);
      if (!bus.ex_rs_used[i] || ex_rs(i) == 0) return 0;
      for (int k = 0; k < NFWD; k++)
         if (bus.fwd_reg_write[k] && int'(bus.fwd_rd[k*AW +: AW]) == ex_rs(i)) return k + 1;
      return 0;
   endfunction

   function automatic bit exp_stall();
      bit haz = 0;
      for (int i = 0; i < NSRC; i++) begin
         if (!bus.id_rs_used[i]) continue;
         if (bus.ex_valid && bus.ex_is_load && bus.ex_reg_write && bus.ex_rd != 0 &&
             id_rs(i) == int'(bus.ex_rd)) haz = 1;
         if (id_rs(i) != 0 && m_pending[id_rs(i)]) haz = 1;
      end
      if (bus.id_reg_write && bus.id_rd != 0 && m_pending[bus.id_rd]) haz = 1;
      if (bus.id_is_mc && m_busy) haz = 1;
      return bus.id_valid && haz;
   endfunction

   function automatic void model_clear();
      m_pending = '0; m_busy = 0; m_err = 0; m_dead = 0; m_cnt = 0;
   endfunction

   // Advance the model by one clock with the currently driven inputs, then
   // wait for the following falling edge (inputs are driven there).
   task automatic tick();
      bit st = exp_stall();
      bit iss = bus.id_valid && !st && bus.id_is_mc;
      if (bus.mc_wb_valid) begin
         m_busy = 0;
         if (bus.mc_wb_rd != 0) begin
            if (m_pending[bus.mc_wb_rd]) m_pending[bus.mc_wb_rd] = 0;
            else m_err = 1;
         end
      end
      if (iss) begin
         m_busy = 1;
         if (bus.id_reg_write && bus.id_rd != 0) m_pending[bus.id_rd] = 1;
      end
      m_cnt = st ? ((m_cnt + 1 > WDOG) ? WDOG : m_cnt + 1) : 0;
      if (m_cnt == WDOG) m_dead = 1;
      @(negedge clk);
   endtask

   // ---------------- drivers ----------------
   task automatic idle();
      bus.ex_rs_addr = '0; bus.ex_rs_used = '0; bus.fwd_reg_write = '0; bus.fwd_rd = '0;
      bus.id_valid = 0; bus.id_rs_addr = '0; bus.id_rs_used = '0; bus.id_rd = '0;
      bus.id_reg_write = 0; bus.id_is_mc = 0; bus.ex_valid = 0; bus.ex_is_load = 0;
      bus.ex_reg_write = 0; bus.ex_rd = '0; bus.mc_wb_valid = 0; bus.mc_wb_rd = '0;
   endtask

   task automatic apply_reset();
      idle();
      rst_n = 0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic drive_mc_issue(int rd);
      idle();
      bus.id_valid = 1; bus.id_is_mc = 1; bus.id_reg_write = 1; bus.id_rd = AW'(rd);
   endtask

   task automatic drive_wb(int rd);
      bus.mc_wb_valid = 1; bus.mc_wb_rd = AW'(rd);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      @(negedge clk);
      #1 rst_n = 0;
      #1;
      checks++; if (bus.pending !== '0) begin errors++; $display("FAIL reset_pending got=%h exp=0", bus.pending); end
      checks++; if (bus.mc_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.mc_busy); end
      checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got=%b exp=0", bus.sb_err); end
      checks++; if (bus.deadlock !== 1'b0) begin errors++; $display("FAIL reset_deadlock got=%b exp=0", bus.deadlock); end
      checks++; if (bus.stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt); end
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall_id); end
      checks++; if (bus.forward_sel !== '0) begin errors++; $display("FAIL reset_fwd got=%h exp=0", bus.forward_sel); end
      model_clear();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_forward();
      int exp;
      idle();
      bus.ex_rs_addr[0 +: AW] = 5; bus.ex_rs_used = 2'b01;
      bus.fwd_rd = {AW'(5), AW'(5)}; bus.fwd_reg_write = 2'b11;
      #1;
      checks++; if (bus.forward_sel[0 +: SELW] !== 2'd1) begin errors++; $display("FAIL fwd_nearest got=%0d exp=1", bus.forward_sel[0 +: SELW]); end
      checks++; if (bus.forward_sel[SELW +: SELW] !== 2'd0) begin errors++; $display("FAIL fwd_unused_op1 got=%0d exp=0", bus.forward_sel[SELW +: SELW]); end
      bus.fwd_reg_write = 2'b10;
      #1;
      checks++; if (bus.forward_sel[0 +: SELW] !== 2'd2) begin errors++; $display("FAIL fwd_memwb got=%0d exp=2", bus.forward_sel[0 +: SELW]); end
      bus.ex_rs_addr[0 +: AW] = 0; bus.fwd_rd = '0; bus.fwd_reg_write = 2'b11;
      #1;
      checks++; if (bus.forward_sel[0 +: SELW] !== 2'd0) begin errors++; $display("FAIL fwd_x0 got=%0d exp=0", bus.forward_sel[0 +: SELW]); end
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < NSRC; i++) bus.ex_rs_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
         for (int k = 0; k < NFWD; k++) bus.fwd_rd[k*AW +: AW] = AW'($urandom_range(0, 3));
         bus.ex_rs_used = NSRC'($urandom);
         bus.fwd_reg_write = NFWD'($urandom);
         #1;
         for (int i = 0; i < NSRC; i++) begin
            exp = exp_fwd(i);
            checks++;
            if (bus.forward_sel[i*SELW +: SELW] !== SELW'(exp)) begin
               errors++; $display("FAIL fwd_rand op%0d got=%0d exp=%0d", i, bus.forward_sel[i*SELW +: SELW], exp);
            end
         end
         #1;
      end
   endtask

   task automatic test_load_use();
      apply_reset();
      bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_reg_write = 1; bus.ex_rd = 7;
      bus.id_valid = 1; bus.id_rs_addr = {AW'(7), AW'(2)}; bus.id_rs_used = 2'b11;
      #1;
      checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL load_use got=%b exp=1", bus.stall_id); end
      tick();
      bus.ex_valid = 0;
      #1;
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL load_use_next got=%b exp=0", bus.stall_id); end
      tick();
      bus.ex_valid = 1; bus.id_rs_used = 2'b01;
      #1;
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL load_use_unused got=%b exp=0", bus.stall_id); end
      tick();
      bus.ex_rd = 0; bus.id_rs_addr = '0; bus.id_rs_used = 2'b11;
      #1;
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL load_use_x0 got=%b exp=0", bus.stall_id); end
      tick();
   endtask

   task automatic test_mc_issue();
      apply_reset();
      drive_mc_issue(9);
      #1;
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL mc_issue_stall got=%b exp=0", bus.stall_id); end
      tick();
      idle(); bus.id_valid = 1; bus.id_rs_addr[0 +: AW] = 9; bus.id_rs_used = 2'b01;
      #1;
      checks++; if (bus.pending[9] !== 1'b1) begin errors++; $display("FAIL mc_pending9 got=%b exp=1", bus.pending[9]); end
      checks++; if (bus.mc_busy !== 1'b1) begin errors++; $display("FAIL mc_busy got=%b exp=1", bus.mc_busy); end
      checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL raw_stall got=%b exp=1", bus.stall_id); end
      tick(); tick();
      drive_wb(9);
      #1;
      checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL raw_stall_wb_cycle got=%b exp=1", bus.stall_id); end
      tick();
      bus.mc_wb_valid = 0;
      #1;
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL raw_release got=%b exp=0", bus.stall_id); end
      checks++; if (bus.pending[9] !== 1'b0 || bus.mc_busy !== 1'b0) begin errors++; $display("FAIL wb_clear pending9=%b busy=%b exp=0,0", bus.pending[9], bus.mc_busy); end
      checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL wb_no_err got=%b exp=0", bus.sb_err); end
      tick();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      drive_mc_issue(5);
      tick();
      drive_mc_issue(3);
      #1;
      checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL struct_stall got=%b exp=1", bus.stall_id); end
      tick();
      drive_wb(5);
      #1;
      checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL struct_stall_wb_cycle got=%b exp=1", bus.stall_id); end
      tick();
      bus.mc_wb_valid = 0;
      #1;
      checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL struct_release got=%b exp=0", bus.stall_id); end
      tick();
      idle();
      #1;
      checks++; if (bus.pending[3] !== 1'b1 || bus.pending[5] !== 1'b0 || bus.mc_busy !== 1'b1) begin
         errors++; $display("FAIL second_issue p3=%b p5=%b busy=%b exp=1,0,1", bus.pending[3], bus.pending[5], bus.mc_busy); end
      drive_wb(3);
      tick();
      // Writeback of rd=3 with no owner alongside a fresh issue to rd=3.
      drive_mc_issue(3); drive_wb(3);
      #1;
      checks++; if (bus.stall_id !== 1'b0 || bus.sb_err !== 1'b0) begin errors++; $display("FAIL pre_same_cycle stall=%b err=%b exp=0,0", bus.stall_id, bus.sb_err); end
      tick();
      idle();
      #1;
      checks++; if (bus.pending[3] !== 1'b1 || bus.mc_busy !== 1'b1 || bus.sb_err !== 1'b1) begin
         errors++; $display("FAIL same_cycle_set p3=%b busy=%b err=%b exp=1,1,1", bus.pending[3], bus.mc_busy, bus.sb_err); end
      tick();
   endtask

   task automatic test_sb_err_and_async_reset();
      apply_reset();
      drive_wb(0);
      tick();
      idle();
      #1;
      checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL wb_x0_err got=%b exp=0", bus.sb_err); end
      drive_wb(12);
      tick();
      idle();
      for (int n = 0; n < 3; n++) begin
         #1;
         checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL sb_err_sticky cyc=%0d got=%b exp=1", n, bus.sb_err); end
         tick();
      end
      drive_mc_issue(9);
      tick();
      idle(); bus.id_valid = 1; bus.id_rs_addr[0 +: AW] = 9; bus.id_rs_used = 2'b01;
      tick();
      #2 rst_n = 0;
      #1;
      checks++; if (bus.pending !== '0 || bus.mc_busy !== 1'b0 || bus.sb_err !== 1'b0 || bus.deadlock !== 1'b0 || bus.stall_cnt !== '0) begin
         errors++; $display("FAIL async_reset pending=%h busy=%b err=%b dead=%b cnt=%0d exp=all 0",
                            bus.pending, bus.mc_busy, bus.sb_err, bus.deadlock, bus.stall_cnt); end
      model_clear();
      idle();
      @(negedge clk);
      rst_n = 1;
      drive_wb(9);
      tick();
      idle();
      #1;
      checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL late_wb_err got=%b exp=1", bus.sb_err); end
      tick();
   endtask

   task automatic test_deadlock();
      apply_reset();
      drive_mc_issue(20);
      tick();
      idle(); bus.id_valid = 1; bus.id_rs_addr[0 +: AW] = 20; bus.id_rs_used = 2'b01;
      for (int c = 1; c <= WDOG + 5; c++) begin
         #1;
         checks++;
         if (bus.stall_id !== 1'b1 || int'(bus.stall_cnt) != ((c - 1 > WDOG) ? WDOG : c - 1) ||
             bus.deadlock !== (c > WDOG)) begin
            errors++; $display("FAIL watchdog cyc=%0d stall=%b cnt=%0d dead=%b exp=1,%0d,%0d", c,
                               bus.stall_id, bus.stall_cnt, bus.deadlock,
                               (c - 1 > WDOG) ? WDOG : c - 1, (c > WDOG));
         end
         tick();
      end
      bus.id_valid = 0;
      #1;
      checks++; if (bus.stall_id !== 1'b0 || bus.deadlock !== 1'b1) begin errors++; $display("FAIL dead_release stall=%b dead=%b exp=0,1", bus.stall_id, bus.deadlock); end
      tick();
      #1;
      checks++; if (bus.stall_cnt !== '0 || bus.deadlock !== 1'b1) begin errors++; $display("FAIL dead_sticky cnt=%0d dead=%b exp=0,1", bus.stall_cnt, bus.deadlock); end
   endtask

   task automatic test_random();
      bit es;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NSRC; i++) begin
            bus.ex_rs_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            bus.id_rs_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
         end
         for (int k = 0; k < NFWD; k++) bus.fwd_rd[k*AW +: AW] = AW'($urandom_range(0, 7));
         bus.ex_rs_used = NSRC'($urandom); bus.fwd_reg_write = NFWD'($urandom);
         bus.id_rs_used = NSRC'($urandom);
         bus.id_valid = ($urandom_range(0, 3) != 0);
         bus.id_rd = AW'($urandom_range(0, 7));
         bus.id_reg_write = $urandom_range(0, 1);
         bus.id_is_mc = ($urandom_range(0, 3) == 0);
         bus.ex_valid = $urandom_range(0, 1); bus.ex_is_load = $urandom_range(0, 1);
         bus.ex_reg_write = $urandom_range(0, 1); bus.ex_rd = AW'($urandom_range(0, 7));
         bus.mc_wb_valid = ($urandom_range(0, 4) == 0); bus.mc_wb_rd = AW'($urandom_range(0, 7));
         #1;
         es = exp_stall();
         for (int i = 0; i < NSRC; i++) begin
            checks++;
            if (bus.forward_sel[i*SELW +: SELW] !== SELW'(exp_fwd(i))) begin
               errors++; $display("FAIL rand_fwd n=%0d op%0d got=%0d exp=%0d", n, i, bus.forward_sel[i*SELW +: SELW], exp_fwd(i));
            end
         end
         checks++;
         if (bus.stall_id !== es || bus.pending !== m_pending || bus.mc_busy !== m_busy ||
             bus.sb_err !== m_err || bus.deadlock !== m_dead || int'(bus.stall_cnt) != m_cnt) begin
            errors++; $display("FAIL rand_state n=%0d stall=%b/%b pend=%h/%h busy=%b/%b err=%b/%b dead=%b/%b cnt=%0d/%0d",
                               n, bus.stall_id, es, bus.pending, m_pending, bus.mc_busy, m_busy,
                               bus.sb_err, m_err, bus.deadlock, m_dead, bus.stall_cnt, m_cnt);
         end
         tick();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle();
      model_clear();
      test_reset();
      test_forward();
      test_load_use();
      test_mc_issue();
      test_back_to_back();
      test_sb_err_and_async_reset();
      test_deadlock();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
